// File: rtl/frame_sequencer.sv
// Frame sequencer: steps one image frame through VSYNC, per-row HSYNC gaps and
// pixel-pair addressing with sink backpressure, latching the frame threshold.
module frame_sequencer #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int START_DELAY  = 100,
  parameter int HSYNC_DELAY  = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        sink_ready,
  input  logic [7:0]  threshold_in,
  output logic        vertical_Pulse,
  output logic        horizontal_Pulse,
  output logic [9:0]  row,
  output logic [10:0] column,
  output logic [7:0]  threshold,
  output logic        busy,
  output logic        done_Flag
);

  localparam int MAX_DLY = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);

  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HSYNC_DELAY - 1);
  localparam logic [10:0]      COL_LAST = 11'(IMAGE_WIDTH - 2);
  localparam logic [9:0]       ROW_LAST = 10'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VSYNC,
    S_HSYNC,
    S_DATA
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_row;
  logic [10:0]      r_col;
  logic [7:0]       r_thr;
  logic             r_done;

  logic w_abort;
  logic w_xfer;
  logic w_row_end;
  logic w_frame_end;
  logic w_launch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort beats both a same-cycle transfer and a same-cycle start
  always_comb begin
    w_next      = r_state;
    w_abort     = abort && (r_state != S_IDLE);
    w_xfer      = (r_state == S_DATA) && sink_ready && !abort;
    w_row_end   = w_xfer && (r_col == COL_LAST);
    w_frame_end = w_row_end && (r_row == ROW_LAST);
    w_launch    = (r_state == S_IDLE) && start && !abort;

    case (r_state)
      S_IDLE: begin
        if (w_launch) w_next = S_VSYNC;
      end
      S_VSYNC: begin
        if (w_abort) w_next = S_IDLE;
        else if (r_cnt == VS_LAST) w_next = S_HSYNC;
      end
      S_HSYNC: begin
        if (w_abort) w_next = S_IDLE;
        else if (r_cnt == HS_LAST) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_abort) w_next = S_IDLE;
        else if (w_frame_end) w_next = S_IDLE;
        else if (w_row_end) w_next = S_HSYNC;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_thr  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;

      // the delay counter restarts on every state change
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == S_VSYNC) || (r_state == S_HSYNC)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_launch) begin
        r_thr <= threshold_in;
        r_row <= '0;
        r_col <= '0;
      end else if (w_abort) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_xfer) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? 10'd0 : r_row + 10'd1;
        end else begin
          r_col <= r_col + 11'd2;
        end
      end
    end
  end

  assign vertical_Pulse   = (r_state == S_VSYNC);
  assign horizontal_Pulse = (r_state == S_DATA);
  assign busy             = (r_state != S_IDLE);
  assign row              = r_row;
  assign column           = r_col;
  assign threshold        = r_thr;
  assign done_Flag        = r_done;

endmodule
